multicycle_controller: RTL

Control unit for the multicycle variant of the `risc_v_32_i` core. A Moore state machine sequences one shared memory, one ALU and the PC/IR/register-file write enables across 3–5 cycles per instruction. It also decodes ALU operation and immediate format from the instruction register fields. It sits between the instruction register and the multicycle datapath, replacing the single-cycle combinational main decoder.

---
 rtl/multicycle_controller_pkg.sv | 55 +++++
 rtl/multicycle_controller_alu_decoder.sv | 27 ++
 rtl/multicycle_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: states, opcodes and control encodings for the multicycle controller
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
      , S_TRAP
`endif
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_RESULT = 1'b1;

   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      return (op == OP_SW) ? IMM_S :
             (op == OP_BEQ) ? IMM_B :
             (op == OP_JAL) ? IMM_J : IMM_I;
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: turns the coarse ALU operation plus funct fields into an ALU opcode
module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   // funct3 selects the operation only for register/immediate ALU instructions
   always_comb begin
      alu_control = ALU_ADD;
      if (alu_op == ALU_OP_SUB)
         alu_control = ALU_SUB;
      else if (alu_op == ALU_OP_FUNCT)
         case (funct3)
            3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
         endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle RV32I datapath; MULTICYCLE_CONTROLLER_TRAP_EN adds a trap on unknown opcodes
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] imm_src,
   output logic       illegal_instr
);

   state_t     state, state_next;
   logic [1:0] alu_op;
   logic       pc_update, branch, ir_wr, mem_wr, reg_wr;

   // State register; reset drops back to FETCH immediately
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= S_FETCH;
      else       state <= state_next;

   // Next state and raw per-state controls
   always_comb begin
      state_next = S_FETCH;
      alu_op     = ALU_OP_ADD;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      result_src = RES_ALUOUT;
      adr_src    = ADR_PC;
      pc_update  = 1'b0;
      branch     = 1'b0;
      ir_wr      = 1'b0;
      mem_wr     = 1'b0;
      reg_wr     = 1'b0;
      case (state)
         S_FETCH: begin
            state_next = S_DECODE;
            ir_wr      = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            pc_update  = 1'b1;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECUTER;
               OP_I:         state_next = S_EXECUTEI;
               OP_JAL:       state_next = S_JAL;
               OP_BEQ:       state_next = S_BEQ;
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
               default:      state_next = S_TRAP;
`else
               default:      state_next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
         end
         S_MEMREAD: begin
            state_next = S_MEMWB;
            adr_src    = ADR_RESULT;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_wr     = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src = ADR_RESULT;
            mem_wr  = 1'b1;
         end
         S_EXECUTER: begin
            state_next = S_ALUWB;
            alu_src_a  = SRCA_RS1;
            alu_op     = ALU_OP_FUNCT;
         end
         S_EXECUTEI: begin
            state_next = S_ALUWB;
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALU_OP_FUNCT;
         end
         S_ALUWB: reg_wr = 1'b1;
         S_JAL: begin
            state_next = S_ALUWB;
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_update  = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALU_OP_SUB;
            branch    = 1'b1;
         end
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
         S_TRAP: state_next = S_TRAP;
`endif
         default: state_next = S_FETCH;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .op5         (op[5]),
      .funct7b5    (funct7b5),
      .alu_control (alu_control)
   );

   assign imm_src   = imm_src_of(op);
   assign pc_write  = ~reset & (pc_update | (branch & zero));
   assign ir_write  = ~reset & ir_wr;
   assign mem_write = ~reset & mem_wr;
   assign reg_write = ~reset & reg_wr;

`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
   assign illegal_instr = ~reset & (state == S_TRAP);
`else
   assign illegal_instr = 1'b0;
`endif

endmodule
